// File: rtl/cva6_ptw_sv32_pkg.sv
// Shared types for the Sv32 page-table walker.
//   pte_sv32_t        : Sv32 page-table entry layout (RISC-V privileged spec order)
//   tlb_update_sv32_t : update record handed to the Sv32 TLB
//   ptw_sv32_state_e  : walker FSM states
//   PLEN_SV32         : physical address width for Sv32 (34 bits)
package cva6_ptw_sv32_pkg;

  localparam int unsigned PLEN_SV32      = 34;
  // The TLB side always carries a full-width ASID; narrower ASIDs are zero-extended.
  localparam int unsigned ASID_MAX_WIDTH = 9;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv32_t;

  typedef struct packed {
    logic                      valid;
    logic                      is_4M;
    logic [19:0]               vpn;
    logic [ASID_MAX_WIDTH-1:0] asid;
    pte_sv32_t                 content;
  } tlb_update_sv32_t;

  typedef enum logic [1:0] {
    PTW_IDLE,
    PTW_REQ,
    PTW_WAIT,
    PTW_DRAIN
  } ptw_sv32_state_e;

endpackage

// File: rtl/cva6_ptw_sv32_pte_check.sv
// Combinational Sv32 PTE classifier.
//   pte_i     : PTE as returned by memory
//   lvl_i     : 1 = root level, 0 = leaf level
//   instr_i   : access is an instruction fetch (needs X)
//   store_i   : access is a data store (needs W and D); must already be 0 for fetches
//   descend_o : valid pointer at the root level, walk one level down
//   leaf_ok_o : usable leaf, translation may be installed
//   fault_o   : page fault
// Exactly one of the three outputs is high for any input.
module cva6_ptw_sv32_pte_check
  import cva6_ptw_sv32_pkg::*;
(
  input  pte_sv32_t pte_i,
  input  logic      lvl_i,
  input  logic      instr_i,
  input  logic      store_i,
  output logic      descend_o,
  output logic      leaf_ok_o,
  output logic      fault_o
);

  logic perm_ok;
  logic unused_pte_bits;

  // Fields that play no part in the decision.
  assign unused_pte_bits = ^{pte_i.ppn[21:10], pte_i.rsw, pte_i.g, pte_i.u};

  // Checks are ordered by priority; the first one that trips decides the outcome.
  always_comb begin
    descend_o = 1'b0;
    leaf_ok_o = 1'b0;
    fault_o   = 1'b0;
    perm_ok   = instr_i ? pte_i.x : (store_i ? pte_i.w : pte_i.r);
    if (!pte_i.v || (!pte_i.r && pte_i.w)) begin
      fault_o = 1'b1;
    end else if (!pte_i.r && !pte_i.x) begin
      if (lvl_i) descend_o = 1'b1;
      else       fault_o   = 1'b1;
    end else if (lvl_i && (pte_i.ppn[9:0] != 10'd0)) begin
      // Megapage whose physical base is not 4 MiB aligned.
      fault_o = 1'b1;
    end else if (!perm_ok) begin
      fault_o = 1'b1;
    end else if (!pte_i.a || (store_i && !pte_i.d)) begin
      // A/D bits are never updated by hardware; software must set them first.
      fault_o = 1'b1;
    end else begin
      leaf_ok_o = 1'b1;
    end
  end

endmodule

// File: rtl/cva6_ptw_sv32.sv
// Sv32 hardware page-table walker.
//   clk_i / rst_ni       : clock, asynchronous active-low reset
//   flush_i              : aborts any walk in progress (SFENCE.VMA / satp write)
//   walk_req_i ...       : TLB miss request (vaddr, instr/store kind, satp root, ASID)
//   mem_*                : single data-cache read port used to fetch PTEs
//   update_o             : one-cycle TLB update pulse (update_instr_o selects ITLB/DTLB)
//   fault_o              : one-cycle page-fault pulse with fault_vaddr_o
//   busy_o               : walk in progress (including draining a flushed read)
module cva6_ptw_sv32
  import cva6_ptw_sv32_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  walk_req_i,
  input  logic [31:0]           walk_vaddr_i,
  input  logic                  walk_instr_i,
  input  logic                  walk_store_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  output logic                  mem_req_o,
  output logic [PLEN_SV32-1:0]  mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output tlb_update_sv32_t      update_o,
  output logic                  update_instr_o,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic [31:0]           fault_vaddr_o
);

  ptw_sv32_state_e       state_q, state_d;
  logic                  lvl_q, lvl_d;
  logic [31:0]           vaddr_q, vaddr_d;
  logic                  instr_q, instr_d;
  logic                  store_q, store_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic [PLEN_SV32-1:0]  mem_addr_q, mem_addr_d;
  tlb_update_sv32_t      update_q, update_d;
  logic                  update_instr_q, update_instr_d;
  logic                  fault_q, fault_d;
  logic [31:0]           fault_vaddr_q, fault_vaddr_d;

  pte_sv32_t rdata_pte;
  logic      pte_descend, pte_leaf_ok, pte_fault;

  assign rdata_pte = pte_sv32_t'(mem_rdata_i);

  cva6_ptw_sv32_pte_check i_pte_check (
    .pte_i     (rdata_pte),
    .lvl_i     (lvl_q),
    .instr_i   (instr_q),
    .store_i   (store_q),
    .descend_o (pte_descend),
    .leaf_ok_o (pte_leaf_ok),
    .fault_o   (pte_fault)
  );

  // Next-state logic. The PTE address is latched when entering REQ so it
  // cannot move while the request waits for a grant. The level-0 address is
  // built from the root PTE at the moment it is read, so that register also
  // holds the pointer PPN for the second read.
  always_comb begin
    state_d        = state_q;
    lvl_d          = lvl_q;
    vaddr_d        = vaddr_q;
    instr_d        = instr_q;
    store_d        = store_q;
    asid_d         = asid_q;
    mem_addr_d     = mem_addr_q;
    update_d       = '0;
    update_instr_d = 1'b0;
    fault_d        = 1'b0;
    fault_vaddr_d  = '0;

    case (state_q)
      PTW_IDLE: begin
        // A flush in the same cycle wins; the request is dropped, not queued.
        if (walk_req_i && !flush_i) begin
          state_d    = PTW_REQ;
          lvl_d      = 1'b1;
          vaddr_d    = walk_vaddr_i;
          instr_d    = walk_instr_i;
          store_d    = walk_store_i && !walk_instr_i;
          asid_d     = asid_i;
          mem_addr_d = {satp_ppn_i, walk_vaddr_i[31:22], 2'b00};
        end
      end
      PTW_REQ: begin
        // A request granted in the flush cycle still owes us an rvalid.
        if (flush_i)        state_d = mem_gnt_i ? PTW_DRAIN : PTW_IDLE;
        else if (mem_gnt_i) state_d = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (flush_i) begin
          // An rvalid coinciding with the flush is the outstanding one; drop it.
          state_d = mem_rvalid_i ? PTW_IDLE : PTW_DRAIN;
        end else if (mem_rvalid_i) begin
          state_d = pte_descend ? PTW_REQ : PTW_IDLE;
          if (pte_descend) begin
            lvl_d      = 1'b0;
            mem_addr_d = {rdata_pte.ppn, vaddr_q[21:12], 2'b00};
          end
          if (pte_leaf_ok) begin
            update_d.valid   = 1'b1;
            update_d.is_4M   = lvl_q;
            update_d.vpn     = vaddr_q[31:12];
            update_d.asid    = ASID_MAX_WIDTH'(asid_q);
            update_d.content = rdata_pte;
            update_instr_d   = instr_q;
          end
          if (pte_fault) begin
            fault_d       = 1'b1;
            fault_vaddr_d = vaddr_q;
          end
        end
      end
      PTW_DRAIN: begin
        if (mem_rvalid_i) state_d = PTW_IDLE;
      end
      default: state_d = PTW_IDLE;
    endcase
  end

  // State and output registers; reset returns to IDLE with every output low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= PTW_IDLE;
      lvl_q          <= 1'b0;
      vaddr_q        <= '0;
      instr_q        <= 1'b0;
      store_q        <= 1'b0;
      asid_q         <= '0;
      mem_addr_q     <= '0;
      update_q       <= '0;
      update_instr_q <= 1'b0;
      fault_q        <= 1'b0;
      fault_vaddr_q  <= '0;
    end else begin
      state_q        <= state_d;
      lvl_q          <= lvl_d;
      vaddr_q        <= vaddr_d;
      instr_q        <= instr_d;
      store_q        <= store_d;
      asid_q         <= asid_d;
      mem_addr_q     <= mem_addr_d;
      update_q       <= update_d;
      update_instr_q <= update_instr_d;
      fault_q        <= fault_d;
      fault_vaddr_q  <= fault_vaddr_d;
    end
  end

  assign mem_req_o      = (state_q == PTW_REQ);
  assign mem_addr_o     = mem_addr_q;
  assign busy_o         = (state_q != PTW_IDLE);
  assign update_o       = update_q;
  assign update_instr_o = update_instr_q;
  assign fault_o        = fault_q;
  assign fault_vaddr_o  = fault_vaddr_q;

endmodule
